output_stream_if: RTL

AXI4-Stream master interface that returns processed results from user logic to the DMA/interconnect. User logic pushes beats (data, keep, last, user) into a 2^DEPTH_BITS-entry FIFO through a simple write/full_n port. A two-entry skid register slice drains the FIFO onto TVALID/TDATA/TKEEP/TLAST/TUSER under full AXI4-Stream backpressure. It is the transmit counterpart of the input stream interface.

---
 rtl/output_stream_if.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/output_stream_if.sv
// -----------------------------------------------------------------------------
// output_stream_if
//
// AXI4-Stream master that returns results from user logic to the interconnect.
// User logic pushes beats {user, last, keep, data} into a 2^DEPTH_BITS-entry
// circular FIFO. A two-entry skid slice drains the FIFO onto the AXI4-Stream
// outputs under full backpressure. All AXI outputs come straight from
// registers, so TVALID never depends combinationally on TREADY.
//
// Optional feature macro: OSIF_AUTO_LAST_EN
//   When defined, osif_frame_len exists and osif_last_din is ignored.
//   TLAST is then generated by a beat counter: a beat is last when
//   cnt == osif_frame_len-1, or on every beat when osif_frame_len == 0.
//   osif_frame_len may only change while the FIFO is empty and cnt == 0.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   osif_data_din    beat data            osif_strb_din  beat byte-keep
//   osif_last_din    beat end-of-packet   osif_user_din  beat sideband
//   osif_write       push request         osif_full_n    FIFO can accept a push
//   osif_frame_len   beats per frame (OSIF_AUTO_LAST_EN only)
//   TVALID/TREADY/TDATA/TKEEP/TLAST/TUSER  AXI4-Stream master
// -----------------------------------------------------------------------------
module output_stream_if #(
    parameter int TBITS      = 32,
    parameter int TBYTE      = 4,
    parameter int DEPTH_BITS = 4,
    parameter int LEN_BITS   = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [TBITS-1:0]    osif_data_din,
    input  logic [TBYTE-1:0]    osif_strb_din,
    input  logic                osif_last_din,
    input  logic                osif_user_din,
    input  logic                osif_write,
    output logic                osif_full_n,
`ifdef OSIF_AUTO_LAST_EN
    input  logic [LEN_BITS-1:0] osif_frame_len,
`endif
    output logic                TVALID,
    input  logic                TREADY,
    output logic [TBITS-1:0]    TDATA,
    output logic [TBYTE-1:0]    TKEEP,
    output logic                TLAST,
    output logic                TUSER
);

    localparam int BW    = TBITS + TBYTE + 2;
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] DEPTH_CNT = (DEPTH_BITS+1)'(DEPTH);

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        ONE  = 2'd1,
        TWO  = 2'd2
    } slice_state_t;

    logic [BW-1:0]         mem_r [DEPTH];
    logic [DEPTH_BITS-1:0] rd_ptr_r;
    logic [DEPTH_BITS-1:0] wr_ptr_r;
    logic [DEPTH_BITS:0]   count_r;
    logic [DEPTH_BITS:0]   count_nxt_s;
    logic                  full_n_r;
    logic                  empty_n_r;
    logic                  push_s;
    logic                  pop_s;
    logic [BW-1:0]         din_s;
    logic [BW-1:0]         fifo_dout_s;
    logic [BW-1:0]         slice_in_s;
    slice_state_t          state_r;
    logic                  s_ready_r;
    logic                  valid_r;
    logic [BW-1:0]         p1_r;
    logic [BW-1:0]         p2_r;

    assign din_s  = {osif_user_din, osif_last_din, osif_strb_din, osif_data_din};
    assign push_s = osif_write & full_n_r;
    assign pop_s  = empty_n_r & s_ready_r;
    assign fifo_dout_s = mem_r[rd_ptr_r];

`ifdef OSIF_AUTO_LAST_EN
    logic [LEN_BITS-1:0] len_cnt_r;
    logic                auto_last_s;

    assign auto_last_s = (osif_frame_len == {LEN_BITS{1'b0}}) |
                         (len_cnt_r == (osif_frame_len - LEN_BITS'(1)));

    // Frame beat counter: advances per pop, clears after the frame's last beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_cnt_r <= {LEN_BITS{1'b0}};
        end else if (pop_s) begin
            if (auto_last_s) begin
                len_cnt_r <= {LEN_BITS{1'b0}};
            end else begin
                len_cnt_r <= len_cnt_r + LEN_BITS'(1);
            end
        end
    end

    // The stored last bit is replaced by the counter's verdict as the beat leaves the FIFO.
    always_comb begin
        slice_in_s         = fifo_dout_s;
        slice_in_s[BW-2]   = auto_last_s;
    end
`else
    assign slice_in_s = fifo_dout_s;
`endif

    // Next occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + (DEPTH_BITS+1)'(1);
            2'b01:   count_nxt_s = count_r - (DEPTH_BITS+1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din_s;
        end
    end

    // FIFO pointers, count and the registered full/empty flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_r  <= {DEPTH_BITS{1'b0}};
            wr_ptr_r  <= {DEPTH_BITS{1'b0}};
            count_r   <= {(DEPTH_BITS+1){1'b0}};
            full_n_r  <= 1'b1;
            empty_n_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + DEPTH_BITS'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + DEPTH_BITS'(1);
            end
            count_r   <= count_nxt_s;
            full_n_r  <= (count_nxt_s != DEPTH_CNT);
            empty_n_r <= (count_nxt_s != {(DEPTH_BITS+1){1'b0}});
        end
    end

    // Two-entry skid slice: p1 drives the bus, p2 catches the beat popped during a stall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ZERO;
            s_ready_r <= 1'b1;
            valid_r   <= 1'b0;
            p1_r      <= {BW{1'b0}};
            p2_r      <= {BW{1'b0}};
        end else begin
            case (state_r)
                ZERO: begin
                    if (pop_s) begin
                        p1_r    <= slice_in_s;
                        valid_r <= 1'b1;
                        state_r <= ONE;
                    end
                end
                ONE: begin
                    if (TREADY && !pop_s) begin
                        valid_r <= 1'b0;
                        state_r <= ZERO;
                    end else if (pop_s && !TREADY) begin
                        p2_r      <= slice_in_s;
                        s_ready_r <= 1'b0;
                        state_r   <= TWO;
                    end else if (pop_s && TREADY) begin
                        p1_r <= slice_in_s;
                    end
                end
                TWO: begin
                    if (TREADY) begin
                        p1_r      <= p2_r;
                        s_ready_r <= 1'b1;
                        state_r   <= ONE;
                    end
                end
                default: begin
                    state_r   <= ZERO;
                    s_ready_r <= 1'b1;
                    valid_r   <= 1'b0;
                end
            endcase
        end
    end

    assign osif_full_n = full_n_r;
    assign TVALID      = valid_r;
    assign TDATA       = p1_r[TBITS-1:0];
    assign TKEEP       = p1_r[TBITS +: TBYTE];
    assign TLAST       = p1_r[BW-2];
    assign TUSER       = p1_r[BW-1];

endmodule
